uart_xcvr: RTL

UART_XCVR -- requirements
Module: uart_xcvr

---
 rtl/uart_xcvr.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver: oversampled TX/RX sharing one sample-tick generator.
// Two-process FSMs on both paths; reset is synchronous and active-low.
module uart_xcvr #(
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned OVERSAMPLE      = 16,
   parameter int unsigned CLKS_PER_SAMPLE = 27,
   parameter bit          PARITY_EN       = 1'b0,
   parameter bit          PARITY_ODD      = 1'b0,
   parameter int unsigned STOP_BITS       = 1
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 transmit_enable,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] P_data_in,
   input  logic                 S_data_in,
   output logic                 S_data_out,
   output logic                 char_sent,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] P_data_out,
   output logic                 char_received,
   output logic                 parity_err,
   output logic                 frame_err
);

   localparam int unsigned TCW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam int unsigned OSW = $clog2(OVERSAMPLE);
   localparam int unsigned BIW = $clog2(DATA_BITS);

   localparam logic [TCW-1:0] TICK_LAST    = TCW'(CLKS_PER_SAMPLE - 1);
   localparam logic [OSW-1:0] OS_LAST      = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] OS_HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [BIW-1:0] BIT_LAST     = BIW'(DATA_BITS - 1);

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

   // ---------------------------------------------------------------- sample tick
   logic [TCW-1:0] tick_cnt_q;
   logic           tick;

   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (!reset || tick) tick_cnt_q <= '0;
      else                tick_cnt_q <= tick_cnt_q + 1'b1;
   end

   // ---------------------------------------------------------------- transmitter
   tx_state_e            tx_state_q, tx_state_d;
   logic [OSW-1:0]       tx_os_q, tx_os_d;
   logic [BIW-1:0]       tx_bit_q, tx_bit_d, tx_bit_nxt;
   logic                 tx_stop_q, tx_stop_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 pending_q, pending_d;
   logic                 tx_line_q, tx_line_d;
   logic                 char_sent_q, char_sent_d;
   logic                 tx_bit_end, tx_par;

   assign tx_bit_end = tick && (tx_os_q == OS_LAST);
   assign tx_bit_nxt = tx_bit_q + 1'b1;
   assign tx_par     = (^hold_q) ^ PARITY_ODD;

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_os_d     = tx_os_q;
      tx_bit_d    = tx_bit_q;
      tx_stop_d   = tx_stop_q;
      hold_d      = hold_q;
      pending_d   = pending_q;
      tx_line_d   = tx_line_q;
      char_sent_d = 1'b0;

      if (tick && tx_state_q != TxIdle) tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;

      unique case (tx_state_q)
         TxIdle: begin
            tx_line_d = 1'b1;
            if (tick && pending_q && transmit_enable) begin
               tx_state_d = TxStart;
               pending_d  = 1'b0;
               tx_os_d    = '0;
               tx_line_d  = 1'b0;
            end else if (load) begin
               hold_d    = P_data_in;
               pending_d = 1'b1;
            end
         end
         TxStart: begin
            if (tx_bit_end) begin
               tx_state_d = TxData;
               tx_bit_d   = '0;
               tx_line_d  = hold_q[0];
            end
         end
         TxData: begin
            if (tx_bit_end) begin
               if (tx_bit_q == BIT_LAST) begin
                  if (PARITY_EN) begin
                     tx_state_d = TxParity;
                     tx_line_d  = tx_par;
                  end else begin
                     tx_state_d = TxStop;
                     tx_stop_d  = 1'b0;
                     tx_line_d  = 1'b1;
                  end
               end else begin
                  tx_bit_d  = tx_bit_nxt;
                  tx_line_d = hold_q[tx_bit_nxt];
               end
            end
         end
         TxParity: begin
            if (tx_bit_end) begin
               tx_state_d = TxStop;
               tx_stop_d  = 1'b0;
               tx_line_d  = 1'b1;
            end
         end
         TxStop: begin
            if (tx_bit_end) begin
               if (STOP_BITS == 2 && !tx_stop_q) begin
                  tx_stop_d = 1'b1;
               end else begin
                  tx_state_d  = TxIdle;
                  char_sent_d = 1'b1;
               end
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         tx_state_q  <= TxIdle;
         tx_os_q     <= '0;
         tx_bit_q    <= '0;
         tx_stop_q   <= 1'b0;
         hold_q      <= '0;
         pending_q   <= 1'b0;
         tx_line_q   <= 1'b1;
         char_sent_q <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_os_q     <= tx_os_d;
         tx_bit_q    <= tx_bit_d;
         tx_stop_q   <= tx_stop_d;
         hold_q      <= hold_d;
         pending_q   <= pending_d;
         tx_line_q   <= tx_line_d;
         char_sent_q <= char_sent_d;
      end
   end

   assign S_data_out = tx_line_q;
   assign tx_busy    = (tx_state_q != TxIdle);
   assign char_sent  = char_sent_q;

   // ---------------------------------------------------------------- receiver
   logic                 rx_meta_q, rx_sync_q;
   rx_state_e            rx_state_q, rx_state_d;
   logic [OSW-1:0]       rx_os_q, rx_os_d;
   logic [BIW-1:0]       rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_par_q, rx_par_d;
   logic                 rx_stop_bad_q, rx_stop_bad_d;
   logic                 rx_done_q, rx_done_d;
   logic                 rx_mid, rx_par_bad;
   logic [DATA_BITS-1:0] data_out_q;
   logic                 par_err_q, frm_err_q, char_rcvd_q;

   assign rx_mid     = tick && (rx_os_q == OS_LAST);
   assign rx_par_bad = PARITY_EN && ((^rx_shift_q) ^ PARITY_ODD ^ rx_par_q);

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_os_d       = rx_os_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_par_d      = rx_par_q;
      rx_stop_bad_d = rx_stop_bad_q;
      rx_done_d     = 1'b0;

      if (tick && rx_state_q != RxIdle) rx_os_d = rx_os_q + 1'b1;

      unique case (rx_state_q)
         RxIdle: begin
            if (tick && !rx_sync_q) begin
               rx_state_d = RxStart;
               rx_os_d    = '0;
            end
         end
         RxStart: begin
            // Half-bit resample centres later samples and rejects short glitches.
            if (tick && rx_os_q == OS_HALF_LAST) begin
               rx_os_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = RxIdle;
               end else begin
                  rx_state_d = RxData;
                  rx_bit_d   = '0;
               end
            end
         end
         RxData: begin
            if (rx_mid) begin
               rx_os_d    = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == BIT_LAST) rx_state_d = PARITY_EN ? RxParity : RxStop;
               else                      rx_bit_d   = rx_bit_q + 1'b1;
            end
         end
         RxParity: begin
            if (rx_mid) begin
               rx_os_d    = '0;
               rx_par_d   = rx_sync_q;
               rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_mid) begin
               rx_stop_bad_d = !rx_sync_q;
               rx_done_d     = 1'b1;
               rx_state_d    = RxIdle;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_state_q    <= RxIdle;
         rx_os_q       <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         rx_par_q      <= 1'b0;
         rx_stop_bad_q <= 1'b0;
         rx_done_q     <= 1'b0;
         data_out_q    <= '0;
         par_err_q     <= 1'b0;
         frm_err_q     <= 1'b0;
         char_rcvd_q   <= 1'b0;
      end else begin
         rx_meta_q     <= S_data_in;
         rx_sync_q     <= rx_meta_q;
         rx_state_q    <= rx_state_d;
         rx_os_q       <= rx_os_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_par_q      <= rx_par_d;
         rx_stop_bad_q <= rx_stop_bad_d;
         rx_done_q     <= rx_done_d;
         char_rcvd_q   <= rx_done_q;
         if (rx_done_q) begin
            data_out_q <= rx_shift_q;
            par_err_q  <= rx_par_bad;
            frm_err_q  <= rx_stop_bad_q;
         end
      end
   end

   assign P_data_out    = data_out_q;
   assign char_received = char_rcvd_q;
   assign parity_err    = par_err_q;
   assign frame_err     = frm_err_q;

endmodule
